// File: rtl/exec_ctrl.sv
// Sequencer driving an external ALU: IDLE -> FETCH -> EXEC -> WB over a small register file.
// Optional EXEC_CTRL_R0_ZERO_EN: reg[0] is hard-wired to zero and writes to it are dropped.
module exec_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] r_sel,
   input  logic [ADDR_W-1:0] s_sel,
   input  logic [ADDR_W-1:0] dst_sel,
   input  logic [3:0]        op_in,
   input  logic              flag_we,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_data,
   output logic [DATA_W-1:0] R,
   output logic [DATA_W-1:0] S,
   output logic [3:0]        Alu_Op,
   input  logic [DATA_W-1:0] Y,
   input  logic              C,
   input  logic              N,
   input  logic              Z,
   output logic [2:0]        status,
   output logic              busy,
   output logic              done,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int unsigned NREG = 2**ADDR_W;

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;
   state_t state, state_nxt;

   logic [DATA_W-1:0] regs [NREG];
   logic [ADDR_W-1:0] r_q, s_q, d_q;
   logic [3:0]        op_q;
   logic              fwe_q;
   logic [DATA_W-1:0] res_q;
   logic [2:0]        flg_q;
   logic              ext_ok, wb_ok;

`ifdef EXEC_CTRL_R0_ZERO_EN
   assign ext_ok = (ext_addr != '0);
   assign wb_ok  = (d_q != '0);
`else
   assign ext_ok = 1'b1;
   assign wb_ok  = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FETCH;
         FETCH:   state_nxt = EXEC;
         EXEC:    state_nxt = WB;
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == WB);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q    <= '0;
         s_q    <= '0;
         d_q    <= '0;
         op_q   <= '0;
         fwe_q  <= 1'b0;
         R      <= '0;
         S      <= '0;
         Alu_Op <= '0;
         res_q  <= '0;
         flg_q  <= '0;
         status <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               r_q   <= r_sel;
               s_q   <= s_sel;
               d_q   <= dst_sel;
               op_q  <= op_in;
               fwe_q <= flag_we;
            end
            FETCH: begin
               R      <= regs[r_q];
               S      <= regs[s_q];
               Alu_Op <= op_q;
            end
            EXEC: begin
               res_q <= Y;
               flg_q <= {C, N, Z};
            end
            WB: if (fwe_q) status <= flg_q;
            default: ;
         endcase
      end
   end

   // External loads and write-back live in disjoint states, so they never collide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (state == IDLE && ext_we && ext_ok) begin
         regs[ext_addr] <= ext_data;
      end else if (state == WB && wb_ok) begin
         regs[d_q] <= res_q;
      end
   end

   assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_exec_ctrl.sv
// Randomised scoreboard bench for exec_ctrl with a behavioural ALU stand-in.
// Honours EXEC_CTRL_R0_ZERO_EN when the design is built with it.
`timescale 1ns/100ps
module tb_exec_ctrl;
   localparam int DW = 16;
   localparam int AW = 3;
`ifdef EXEC_CTRL_R0_ZERO_EN
   localparam bit R0Z = 1'b1;
`else
   localparam bit R0Z = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic start, flag_we, ext_we;
   logic [AW-1:0] r_sel, s_sel, dst_sel, ext_addr, dbg_addr;
   logic [3:0] op_in, Alu_Op;
   logic [DW-1:0] ext_data, R, S, Y, dbg_data;
   logic C, N, Z, busy, done;
   logic [2:0] status;

   exec_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .r_sel(r_sel), .s_sel(s_sel),
      .dst_sel(dst_sel), .op_in(op_in), .flag_we(flag_we), .ext_we(ext_we),
      .ext_addr(ext_addr), .ext_data(ext_data), .R(R), .S(S), .Alu_Op(Alu_Op),
      .Y(Y), .C(C), .N(N), .Z(Z), .status(status), .busy(busy), .done(done),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ALU: returns {C, N, Z, Y}
   function automatic logic [DW+2:0] alu(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0] t;
      case (op)
         4'b0000: t = {1'b0, a & b};
         4'b0001: t = {1'b0, a};
         4'b0010: t = {1'b0, a} + {1'b0, b};
         4'b0011: t = {1'b0, a} - {1'b0, b};
         4'b0100: t = {1'b0, a | b};
         4'b0101: t = {1'b0, a ^ b};
         default: t = {1'b0, ~a};
      endcase
      return {t[DW], t[DW-1], (t[DW-1:0] == '0), t[DW-1:0]};
   endfunction

   always_comb {C, N, Z, Y} = alu(Alu_Op, R, S);

   typedef struct {
      logic [DW-1:0] r, s;
      logic [3:0] op;
      logic [2:0] st;
      int cyc;
   } exp_t;
   exp_t q[$];

   logic [DW-1:0] m [8];
   logic [2:0] mst;
   int vectors = 0, miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic m_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (!(R0Z && a == '0)) m[a] = d;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      case ($urandom_range(0, 3))
         0: return '0;
         1: return '1;
         2: return DW'(16'h8000);
         default: return DW'($urandom);
      endcase
   endfunction

   task automatic idle_cycle(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      start = 1'b0; ext_we = we; ext_addr = a; ext_data = d;
      if (we) m_write(a, d);
   endtask

   task automatic do_op(input logic [AW-1:0] rs, input logic [AW-1:0] ss, input logic [AW-1:0] ds,
                        input logic [3:0] op, input bit fwe,
                        input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      exp_t e;
      logic [DW+2:0] res;
      @(negedge clk);
      start = 1'b1; r_sel = rs; s_sel = ss; dst_sel = ds; op_in = op; flag_we = fwe;
      ext_we = we; ext_addr = wa; ext_data = wd;
      if (we) m_write(wa, wd);
      e.r = m[rs]; e.s = m[ss]; e.op = op;
      res = alu(op, e.r, e.s);
      if (fwe) mst = res[DW+2:DW];
      e.st = mst;
      e.cyc = cyc + 3;
      m_write(ds, res[DW-1:0]);
      q.push_back(e);
      // While busy: ext writes (FETCH) and new starts (EXEC) must be ignored
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = (i == 1) ? 1'b1 : 1'($urandom);
         ext_we = (i == 0) ? 1'b1 : 1'($urandom);
         ext_addr = AW'($urandom); ext_data = rnd_data();
         r_sel = AW'($urandom); s_sel = AW'($urandom); dst_sel = AW'($urandom);
         op_in = 4'($urandom); flag_we = 1'($urandom);
      end
   endtask

   task automatic check_regs();
      @(negedge clk);
      start = 1'b0; ext_we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         dbg_addr = AW'(i);
         #1;
         chk($sformatf("reg%0d", i), dbg_data, m[i]);
      end
      chk("status_idle", status, mst);
      chk("busy_idle", busy, 1'b0);
   endtask

   task automatic chk_reg(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      @(negedge clk);
      start = 1'b0; ext_we = 1'b0;
      dbg_addr = a;
      #1;
      chk(nm, dbg_data, exp);
   endtask

   task automatic reset_op();
      @(negedge clk);
      start = 1'b1; r_sel = 3'd1; s_sel = 3'd2; dst_sel = 3'd6; op_in = 4'b0010; flag_we = 1'b1;
      ext_we = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_status", status, 3'b000);
      chk("rst_R", R, 0);
      chk("rst_op", Alu_Op, 4'b0000);
      for (int i = 0; i < 8; i++) m[i] = '0;
      mst = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: every done pulse must match the oldest outstanding request
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && done === 1'b1) begin
            if (q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL spurious_done: got done=1 expected no pending request (t=%0t)", $time);
            end else begin
               e = q.pop_front();
               chk("done_latency", cyc, e.cyc);
               chk("R", R, e.r);
               chk("S", S, e.s);
               chk("Alu_Op", Alu_Op, e.op);
               @(posedge clk);
               #1;
               chk("status_wb", status, e.st);
               chk("busy_after", busy, 1'b0);
               chk("done_single", done, 1'b0);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; flag_we = 1'b0; ext_we = 1'b0;
      r_sel = '0; s_sel = '0; dst_sel = '0; ext_addr = '0; dbg_addr = '0;
      op_in = '0; ext_data = '0;
      for (int i = 0; i < 8; i++) m[i] = '0;
      mst = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_R", R, 0);
      chk("reset_S", S, 0);
      chk("reset_op", Alu_Op, 0);
      chk("reset_status", status, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      @(negedge clk);
      reset = 1'b0;
      check_regs();

      idle_cycle(1, 3'd1, 16'h0005);
      idle_cycle(1, 3'd2, 16'h0003);
      do_op(3'd1, 3'd2, 3'd3, 4'b0010, 1'b1, 1'b0, 3'd0, 16'h0);
      chk_reg("add_r3", 3'd3, 16'h0008);
      chk("add_status", status, 3'b000);

      do_op(3'd1, 3'd1, 3'd4, 4'b0011, 1'b1, 1'b0, 3'd0, 16'h0);
      chk_reg("sub_r4", 3'd4, 16'h0000);
      chk("sub_status", status, 3'b001);

      idle_cycle(1, 3'd1, 16'hFFFF);
      idle_cycle(1, 3'd2, 16'h0001);
      do_op(3'd1, 3'd2, 3'd5, 4'b0010, 1'b1, 1'b0, 3'd0, 16'h0);
      chk_reg("carry_r5", 3'd5, 16'h0000);
      chk("carry_status", status, 3'b101);
      do_op(3'd1, 3'd2, 3'd5, 4'b0010, 1'b0, 1'b0, 3'd0, 16'h0);
      do_op(3'd2, 3'd2, 3'd5, 4'b0001, 1'b0, 1'b0, 3'd0, 16'h0);
      chk("nofwe_status", status, 3'b101);
      chk_reg("busy_ext_r2", 3'd2, 16'h0001);
      check_regs();

      // Simultaneous ext write and start: operand sees the new value
      do_op(3'd3, 3'd3, 3'd1, 4'b0001, 1'b0, 1'b1, 3'd3, 16'h00AA);
      chk_reg("wr_first_r1", 3'd1, 16'h00AA);

      reset_op();
      check_regs();
      chk_reg("abort_r6", 3'd6, 16'h0000);

      idle_cycle(1, 3'd0, 16'h1234);
      do_op(3'd0, 3'd0, 3'd7, 4'b0001, 1'b1, 1'b0, 3'd0, 16'h0);
      chk_reg("r0_r7", 3'd7, R0Z ? 16'h0000 : 16'h1234);
      check_regs();

      for (int it = 0; it < 300; it++) begin
         repeat ($urandom_range(0, 2))
            idle_cycle(1'($urandom), AW'($urandom), rnd_data());
         do_op(AW'($urandom), AW'($urandom), AW'($urandom), 4'($urandom_range(0, 7)),
               1'($urandom), ($urandom_range(0, 3) == 0), AW'($urandom), rnd_data());
         if (it % 10 == 9) check_regs();
      end
      check_regs();
      repeat (4) @(negedge clk);
      chk("queue_empty", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register and operand width.
REQ-002 SHALL have parameter ADDR_W, default 3, register-select width (2**ADDR_W registers).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, request to execute one operation.
REQ-006 SHALL have ports r_sel, s_sel, dst_sel, input, ADDR_W each, selecting the R source, S source and destination registers.
REQ-007 SHALL have port op_in, input, 4, ALU opcode for the request.
REQ-008 SHALL have port flag_we, input, 1, request updates the status register when 1.
REQ-009 SHALL have ports ext_we (input, 1), ext_addr (input, ADDR_W) and ext_data (input, DATA_W), an external register-load port.
REQ-010 SHALL have ports R, S, output, DATA_W each, registered operands to the ALU.
REQ-011 SHALL have port Alu_Op, output, 4, registered opcode to the ALU.
REQ-012 SHALL have ports Y (input, DATA_W) and C, N, Z (input, 1 each), ALU result and flags.
REQ-013 SHALL have port status, output, 3, registered flags {C,N,Z}.
REQ-014 SHALL have ports busy (output, 1, high when not IDLE) and done (output, 1, single-cycle completion pulse).
REQ-015 SHALL have ports dbg_addr (input, ADDR_W) and dbg_data (output, DATA_W), a combinational read of the register file.

Function
REQ-016 SHALL implement an FSM with states IDLE, FETCH, EXEC, WB.
REQ-017 In IDLE with start=1, SHALL latch r_sel, s_sel, dst_sel, op_in and flag_we, then go to FETCH.
REQ-018 In FETCH, SHALL load R=reg[r_sel], S=reg[s_sel] and Alu_Op=op latched, then go to EXEC.
REQ-019 In EXEC, SHALL capture Y into a result register and {C,N,Z} into a flag holding register, then go to WB.
REQ-020 In WB, SHALL write the result to reg[dst_sel]; if the latched flag_we=1, SHALL load status from the held flags; SHALL assert done for that cycle only; SHALL return to IDLE.
REQ-021 Latency SHALL be fixed: done high exactly 3 cycles after the edge that accepts start; the next start SHALL be accepted in the cycle after done.
REQ-022 start while busy=1 SHALL be ignored, with no queuing.
REQ-023 ext_we SHALL write reg[ext_addr]=ext_data only in IDLE; it SHALL be ignored in all other states.
REQ-024 With ext_we and start together in IDLE, the write SHALL take effect first, so FETCH reads the new value.
REQ-025 R, S and Alu_Op SHALL hold their values outside FETCH.
REQ-026 status SHALL change only in WB with flag_we=1.
REQ-027 dst_sel equal to r_sel or s_sel SHALL be legal; the write occurs in WB after the operands are read.

Reset
REQ-028 On reset: state=IDLE; all registers, R, S and the result register =0; Alu_Op=4'b0000; status=3'b000; busy=0; done=0.
REQ-029 Reset asserted mid-operation SHALL abort immediately with no register write and no done pulse.

Configuration
REQ-030 With macro EXEC_CTRL_R0_ZERO_EN defined, reg[0] SHALL read as 0 on all ports and writes to it SHALL be discarded; undefined, reg[0] SHALL be an ordinary register.

Verification
(bench connects exec_ctrl to the team's alu module)
REQ-031 Write r1=0x0005, r2=0x0003 via ext; start op 0010, r_sel=1, s_sel=2, dst=3, flag_we=1 -> done 3 cycles after start; reg3=0x0008; status=000.
REQ-032 With r1=0x0005, start op 0011, r=1, s=1, dst=4, flag_we=1 -> reg4=0x0000; status Z=1 (status=001).
REQ-033 Write r1=0xFFFF, r2=0x0001; op 0010, dst=5 -> reg5=0x0000; status C=1, Z=1 (101); repeat with flag_we=0 -> status unchanged.
REQ-034 Pulse start again during EXEC, and assert ext_we to r2 during FETCH -> only one done pulse; r2 unchanged.
REQ-035 Assert reset during EXEC of a write to r6 -> r6=0; done never pulses; busy=0 next cycle; status=000.
REQ-036 With EXEC_CTRL_R0_ZERO_EN defined, ext write 0x1234 to r0, then op 0001 r=0, dst=7 -> reg7=0x0000, Z=1; undefined -> reg7=0x1234.
